// File: rtl/param_cfg_sequencer.sv
// -----------------------------------------------------------------------------
// param_cfg_sequencer
//
// Loads and applies the four configuration fields (W, X, Y, Z) of a
// parameterised datapath block at run time. Two requesters share one shadow
// register set:
//   - a named port (field select + value, optional commit), and
//   - a positional stream (values in order W, X, Y, Z; may stop early with
//     ps_last).
// A commit copies shadow -> active in one cycle and pulses cfg_update.
//
// Build option:
//   PCS_AUTO_COMMIT_EN  defined   : end of a positional session commits.
//                       undefined : end of a positional session returns to
//                                   IDLE; only nm_commit / commit_req commit.
//
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   nm_valid/nm_ready       named write handshake
//   nm_sel, nm_data         field select (0=W 1=X 2=Y 3=Z) and value
//   nm_commit               commit after this named write
//   ps_valid/ps_ready       positional beat handshake
//   ps_data, ps_last        positional value, final beat of session
//   commit_req              standalone commit request (level, used in IDLE)
//   cfg_hold                downstream busy; holds off a pending commit
//   cfg_w/x/y/z             active configuration (Y is 8 bits)
//   cfg_update              one-cycle pulse when the active set is loaded
//   busy                    controller not in IDLE
// -----------------------------------------------------------------------------
module param_cfg_sequencer #(
    parameter int unsigned     DW    = 32,
    parameter logic [DW-1:0]   DEF_W = DW'(9),
    parameter logic [DW-1:0]   DEF_X = DW'(9),
    parameter logic [7:0]      DEF_Y = 8'd9,
    parameter logic [DW-1:0]   DEF_Z = DW'(9)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          nm_valid,
    output logic          nm_ready,
    input  logic [1:0]    nm_sel,
    input  logic [DW-1:0] nm_data,
    input  logic          nm_commit,
    input  logic          ps_valid,
    output logic          ps_ready,
    input  logic [DW-1:0] ps_data,
    input  logic          ps_last,
    input  logic          commit_req,
    input  logic          cfg_hold,
    output logic [DW-1:0] cfg_w,
    output logic [DW-1:0] cfg_x,
    output logic [7:0]    cfg_y,
    output logic [DW-1:0] cfg_z,
    output logic          cfg_update,
    output logic          busy
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_POS    = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    // Where a positional session goes once its last field is written.
`ifdef PCS_AUTO_COMMIT_EN
    localparam state_t SESSION_END_ST = ST_COMMIT;
`else
    localparam state_t SESSION_END_ST = ST_IDLE;
`endif

    state_t        state_q;
    logic          rr_pos_q;      // 1: positional requester wins the next tie
    logic [1:0]    beat_q;        // index of the next positional field
    logic          cfg_update_q;

    logic [DW-1:0] sh_w_q, sh_x_q, sh_z_q;
    logic [7:0]    sh_y_q;
    logic [DW-1:0] act_w_q, act_x_q, act_z_q;
    logic [7:0]    act_y_q;

    logic          nm_fire, ps_fire;
    logic          wr_en;
    logic [1:0]    wr_sel;
    logic [DW-1:0] wr_data;

    // Ready generation: in IDLE a contended pair is resolved by rr_pos_q, so
    // exactly one side is ready when both are valid.
    always_comb begin
        nm_ready = 1'b0;
        ps_ready = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                nm_ready = !ps_valid || !rr_pos_q;
                ps_ready = !nm_valid ||  rr_pos_q;
            end
            ST_POS:  ps_ready = 1'b1;
            default: ;
        endcase
    end

    assign nm_fire = nm_valid && nm_ready;
    assign ps_fire = ps_valid && ps_ready;

    // Shadow write port shared by both requesters. A positional beat
    // accepted in IDLE is always beat 0 (field W).
    always_comb begin
        wr_en   = nm_fire || ps_fire;
        wr_data = nm_fire ? nm_data : ps_data;
        if (nm_fire)
            wr_sel = nm_sel;
        else if (state_q == ST_IDLE)
            wr_sel = 2'd0;
        else
            wr_sel = beat_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_pos_q     <= 1'b0;
            beat_q       <= 2'd0;
            cfg_update_q <= 1'b0;
            sh_w_q       <= DEF_W;
            sh_x_q       <= DEF_X;
            sh_y_q       <= DEF_Y;
            sh_z_q       <= DEF_Z;
            act_w_q      <= DEF_W;
            act_x_q      <= DEF_X;
            act_y_q      <= DEF_Y;
            act_z_q      <= DEF_Z;
        end else begin
            cfg_update_q <= 1'b0;

            if (wr_en) begin
                unique case (wr_sel)
                    2'd0: sh_w_q <= wr_data;
                    2'd1: sh_x_q <= wr_data;
                    2'd2: sh_y_q <= wr_data[7:0];
                    default: sh_z_q <= wr_data;
                endcase
            end

            unique case (state_q)
                ST_IDLE: begin
                    if (nm_fire) begin
                        if (ps_valid)
                            rr_pos_q <= 1'b1;
                        state_q <= nm_commit ? ST_COMMIT : ST_IDLE;
                    end else if (ps_fire) begin
                        if (nm_valid)
                            rr_pos_q <= 1'b0;
                        if (ps_last) begin
                            beat_q  <= 2'd0;
                            state_q <= SESSION_END_ST;
                        end else begin
                            beat_q  <= 2'd1;
                            state_q <= ST_POS;
                        end
                    end else if (commit_req) begin
                        state_q <= ST_COMMIT;
                    end
                end
                ST_POS: begin
                    // Beat 3 (field Z) always closes the session.
                    if (ps_fire) begin
                        if (ps_last || beat_q == 2'd3) begin
                            beat_q  <= 2'd0;
                            state_q <= SESSION_END_ST;
                        end else begin
                            beat_q  <= beat_q + 2'd1;
                        end
                    end
                end
                ST_COMMIT: begin
                    if (!cfg_hold) begin
                        act_w_q      <= sh_w_q;
                        act_x_q      <= sh_x_q;
                        act_y_q      <= sh_y_q;
                        act_z_q      <= sh_z_q;
                        cfg_update_q <= 1'b1;
                        state_q      <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign cfg_w      = act_w_q;
    assign cfg_x      = act_x_q;
    assign cfg_y      = act_y_q;
    assign cfg_z      = act_z_q;
    assign cfg_update = cfg_update_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
